// File: rtl/ssd_capture_pkg.sv
// Shared constants and types for the multiplexed 7-segment display reader.
package ssd_capture_pkg;

  // Active-low segment codes (bit6=g .. bit0=a), entry i shows hex digit i.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // All segments dark: digit intentionally blanked by the driver.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_capture_if.sv
// Display bus seen by the capture block plus the recovered digit outputs.
interface ssd_capture_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg_in;
  logic [NDIG-1:0]   an_in;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dig_valid;
  logic              upd;
  logic [2:0]        upd_idx;
  logic              err;

  // Display driver / stimulus side.
  modport master (
    output seg_in, an_in,
    input  digits, dig_valid, upd, upd_idx, err
  );

  // Capture block side.
  modport slave (
    input  seg_in, an_in,
    output digits, dig_valid, upd, upd_idx, err
  );
endinterface

// File: rtl/ssd_capture_seg2hex.sv
// Combinational decoder from an active-low segment pattern to a hex nibble.
module ssd_seg2hex
  import ssd_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] hex
);

  // Table search; codes are unique so at most one entry matches.
  always_comb begin
    legal = 1'b0;
    hex   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      legal = legal | (seg == SEG_CODE[i]);
      hex   = (seg == SEG_CODE[i]) ? i[3:0] : hex;
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/ssd_capture.sv
// Reads a multiplexed active-low 7-segment bus and recovers the hex value per digit.
module ssd_capture
  import ssd_capture_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  ssd_capture_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic [6:0]        s_seg_r;
  logic [NDIG-1:0]   s_an_r;
  logic [6:0]        ref_seg_r;
  logic [NDIG-1:0]   ref_an_r;
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   valid_r;
  logic              upd_r;
  logic              err_r;
  logic [2:0]        idx_r;

  logic [NDIG-1:0]   low_s;
  logic              cand_s;
  logic              same_s;
  logic [NDIG-1:0]   sel_s;
  logic [2:0]        ref_idx_s;
  logic              legal_s;
  logic              blank_s;
  logic [3:0]        hex_s;

  ssd_seg2hex u_dec (
    .seg   (ref_seg_r),
    .legal (legal_s),
    .blank (blank_s),
    .hex   (hex_s)
  );

  // Candidate detection on the sampled bus and index of the reference digit.
  always_comb begin
    low_s     = ~s_an_r;
    cand_s    = (low_s != {NDIG{1'b0}}) && ((low_s & (low_s - NDIG'(1))) == {NDIG{1'b0}});
    same_s    = (s_seg_r == ref_seg_r) && (s_an_r == ref_an_r);
    sel_s     = ~ref_an_r;
    ref_idx_s = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      ref_idx_s = ref_an_r[i] ? ref_idx_s : 3'(i);
    end
  end

  // Input sampling, stability FSM and per-digit commit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_r   <= 7'h7F;
      s_an_r    <= {NDIG{1'b1}};
      ref_seg_r <= 7'h7F;
      ref_an_r  <= {NDIG{1'b1}};
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      digits_r  <= {(4*NDIG){1'b0}};
      valid_r   <= {NDIG{1'b0}};
      upd_r     <= 1'b0;
      err_r     <= 1'b0;
      idx_r     <= 3'd0;
    end else begin
      s_seg_r <= bus.seg_in;
      s_an_r  <= bus.an_in;
      upd_r   <= 1'b0;
      err_r   <= 1'b0;
      if (state_r == SETTLE && same_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_r <= HOLD;
          if (legal_s) begin
            valid_r <= valid_r | sel_s;
            upd_r   <= 1'b1;
            idx_r   <= ref_idx_s;
            for (int i = 0; i < NDIG; i++) begin
              if (sel_s[i]) begin
                digits_r[4*i +: 4] <= hex_s;
              end else begin
                digits_r[4*i +: 4] <= digits_r[4*i +: 4];
              end
            end
          end else if (blank_s) begin
            valid_r <= valid_r & ~sel_s;
          end else begin
            valid_r <= valid_r & ~sel_s;
            err_r   <= 1'b1;
            idx_r   <= ref_idx_s;
          end
        end else begin
          state_r <= SETTLE;
        end
      end else if (state_r == HOLD && same_s) begin
        state_r <= HOLD;
      end else if (cand_s) begin
        // Fresh window on any new single-digit pattern (IDLE, change in SETTLE/HOLD).
        state_r   <= SETTLE;
        ref_seg_r <= s_seg_r;
        ref_an_r  <= s_an_r;
        cnt_r     <= CNT_W'(1);
      end else begin
        state_r <= IDLE;
        cnt_r   <= {CNT_W{1'b0}};
      end
    end
  end

  assign bus.digits    = digits_r;
  assign bus.dig_valid = valid_r;
  assign bus.upd       = upd_r;
  assign bus.err       = err_r;
  assign bus.upd_idx   = idx_r;

endmodule
